// File: rtl/seg7_scan_display.sv
// Scans a 16-bit value onto a 4-digit common-anode seven-segment display.
// The value is snapshotted once per frame and each digit slot starts with a dark gap to suppress ghosting.
module seg7_scan_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit LZ_BLANK     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic [3:0]  dp_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;

    logic             slot_end;
    logic             in_gap;
    logic             lz_hidden;
    logic [3:0]       nibble;

    // Active-low gfedcba patterns for each hex digit.
    function automatic logic [6:0] decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0: pattern = 7'h40;
            4'h1: pattern = 7'h79;
            4'h2: pattern = 7'h24;
            4'h3: pattern = 7'h30;
            4'h4: pattern = 7'h19;
            4'h5: pattern = 7'h12;
            4'h6: pattern = 7'h02;
            4'h7: pattern = 7'h78;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h10;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h03;
            4'hC: pattern = 7'h46;
            4'hD: pattern = 7'h21;
            4'hE: pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    // A zero-length gap must not produce a constant unsigned compare.
    generate
        if (BLANK_CYCLES > 0) begin : g_gap
            assign in_gap = (cnt_q < BLANK_LIM);
        end else begin : g_no_gap
            assign in_gap = 1'b0;
        end
    endgenerate

    always_comb begin
        slot_end = (cnt_q == CNT_MAX);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        digit_d  = slot_end ? digit_q + 2'd1 : digit_q;
        shadow_d = (slot_end && (digit_q == 2'd3)) ? data : shadow_q;
    end

    // Digit 0 always shows; higher digits hide when they and everything above are zero.
    always_comb begin
        lz_hidden = 1'b0;
        if (LZ_BLANK) begin
            case (digit_q)
                2'd1:    lz_hidden = (shadow_q[15:4] == 12'h000);
                2'd2:    lz_hidden = (shadow_q[15:8] == 8'h00);
                2'd3:    lz_hidden = (shadow_q[15:12] == 4'h0);
                default: lz_hidden = 1'b0;
            endcase
        end
    end

    always_comb begin
        nibble = shadow_q[4*digit_q +: 4];
        seg_d  = SEG_OFF;
        dp_d   = 1'b1;
        an_d   = AN_OFF;
        if (!in_gap && !lz_hidden) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = decode(nibble);
            dp_d  = ~dp_en[digit_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            digit_q  <= 2'd0;
            shadow_q <= 16'h0000;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            an_q     <= AN_OFF;
        end else begin
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized bench for seg7_scan_display: three configurations run side by side against a
// time-indexed reference model of the scan, snapshot, blanking and decode rules.
module tb_seg7_scan_display;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;
    localparam logic [11:0] DARK = {4'hF, 1'b1, 7'h7F};

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] data = 16'h1234;
    logic [3:0]  dp_en = 4'h0;

    logic [6:0]  seg_a, seg_b, seg_c;
    logic        dp_a, dp_b, dp_c;
    logic [3:0]  an_a, an_b, an_c;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state: edges since reset release and the frame snapshot.
    int          model_n = 0;
    logic [15:0] model_shadow = 16'h0000;
    logic [11:0] exp_a = DARK, exp_b = DARK, exp_c = DARK;

    always #5 clk = ~clk;

    // Plain gap, leading-zero blanking, and no-gap variants.
    seg7_scan_display #(.REFRESH_DIV(DIV), .BLANK_CYCLES(1), .LZ_BLANK(1'b0)) dut_a (
        .clk(clk), .reset(reset), .data(data), .dp_en(dp_en),
        .seg(seg_a), .dp(dp_a), .an(an_a));

    seg7_scan_display #(.REFRESH_DIV(DIV), .BLANK_CYCLES(1), .LZ_BLANK(1'b1)) dut_b (
        .clk(clk), .reset(reset), .data(data), .dp_en(dp_en),
        .seg(seg_b), .dp(dp_b), .an(an_b));

    seg7_scan_display #(.REFRESH_DIV(DIV), .BLANK_CYCLES(0), .LZ_BLANK(1'b0)) dut_c (
        .clk(clk), .reset(reset), .data(data), .dp_en(dp_en),
        .seg(seg_c), .dp(dp_c), .an(an_c));

    // Expected {an, dp, seg} for the slot position pos of digit dig.
    function automatic logic [11:0] model_out(input int pos, input int dig, input logic [15:0] sh,
                                              input logic [3:0] dpe, input int blank, input bit lz);
        logic [15:0] upper;
        logic [3:0]  lit_an;
        upper = sh >> (4 * dig);
        if (pos < blank) return DARK;
        if (lz && dig > 0 && upper == 16'h0000) return DARK;
        lit_an = ~(4'b0001 << dig);
        return {lit_an, ~dpe[dig], SEG_TAB[upper[3:0]]};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_n      = 0;
            model_shadow = 16'h0000;
            exp_a        = DARK;
            exp_b        = DARK;
            exp_c        = DARK;
        end else begin
            exp_a = model_out(model_n % DIV, (model_n / DIV) % 4, model_shadow, dp_en, 1, 1'b0);
            exp_b = model_out(model_n % DIV, (model_n / DIV) % 4, model_shadow, dp_en, 1, 1'b1);
            exp_c = model_out(model_n % DIV, (model_n / DIV) % 4, model_shadow, dp_en, 0, 1'b0);
            if (model_n % FRAME == FRAME - 1) model_shadow = data;
            model_n = model_n + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] expected);
        check_count++;
        if (got === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, expected, $time);
    endtask

    task automatic checkAll();
        checkOutput("seg_a", 16'(seg_a), 16'(exp_a[6:0]));
        checkOutput("dp_a",  16'(dp_a),  16'(exp_a[7]));
        checkOutput("an_a",  16'(an_a),  16'(exp_a[11:8]));
        checkOutput("seg_b", 16'(seg_b), 16'(exp_b[6:0]));
        checkOutput("dp_b",  16'(dp_b),  16'(exp_b[7]));
        checkOutput("an_b",  16'(an_b),  16'(exp_b[11:8]));
        checkOutput("seg_c", 16'(seg_c), 16'(exp_c[6:0]));
        checkOutput("dp_c",  16'(dp_c),  16'(exp_c[7]));
        checkOutput("an_c",  16'(an_c),  16'(exp_c[11:8]));
        checkOutput("onehot_a", 16'($countones(~an_a) <= 1), 16'd1);
        checkOutput("onehot_c", 16'($countones(~an_c) <= 1), 16'd1);
    endtask

    bit tear_done = 1'b0;

    task automatic applyStimulus(input int cyc);
        logic [15:0] mask;
        if (cyc == 3) reset = 1'b1;
        if (cyc < 40) begin
            data  = 16'h1234;
            dp_en = 4'h0;
        end else if (cyc < 60) begin
            data = 16'hABCD;
        end else if (cyc < 100) begin
            if (!tear_done && (model_n % FRAME) / DIV == 1) begin
                data      = 16'hEF01;
                tear_done = 1'b1;
            end
        end else if (cyc < 160) begin
            data = 16'h0050;
        end else if (cyc < 220) begin
            data = 16'h0000;
        end else if (cyc < 300) begin
            dp_en = 4'b0100;
            if ($urandom_range(7) == 0) data = 16'($urandom);
        end else begin
            if ($urandom_range(5) == 0) begin
                case ($urandom_range(4))
                    0:       mask = 16'hFFFF;
                    1:       mask = 16'h0FFF;
                    2:       mask = 16'h00FF;
                    3:       mask = 16'h000F;
                    default: mask = 16'h0000;
                endcase
                data = 16'($urandom) & mask;
            end
            if ($urandom_range(15) == 0) dp_en = 4'($urandom);
        end
    endtask

    int release_at = -1;
    bit async_done = 1'b0;

    initial begin
        $display("[TB] start");
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checkOutput("rst_seg", 16'(seg_a), 16'h007F);
                checkOutput("rst_an",  16'(an_a),  16'h000F);
                checkOutput("rst_dp",  16'(dp_a),  16'h0001);
            end
            checkAll();
            applyStimulus(cyc);
            if (cyc == release_at) reset = 1'b1;
            if (!async_done && cyc >= 600 && reset && model_n % FRAME == 2 * DIV + 2) begin
                async_done = 1'b1;
                #2 reset = 1'b0;
                #1;
                checkOutput("async_an_a",  16'(an_a),  16'h000F);
                checkOutput("async_seg_a", 16'(seg_a), 16'h007F);
                checkOutput("async_an_b",  16'(an_b),  16'h000F);
                checkOutput("async_an_c",  16'(an_c),  16'h000F);
                release_at = cyc + 3;
            end
        end
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream consumer of the board wrapper's 16-bit debug value (processor result bus); renders it as 4 hex digits on the Basys 4-digit common-anode seven-segment display.
- Time-multiplexes digits with a programmable refresh prescaler and inserts an inter-digit blanking gap to suppress ghosting.
- Snapshots the input once per frame so a value changing mid-scan never tears across digits.
- Runs on the board oscillator, not the divided CPU clock.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot; legal range >= 2.
- BLANK_CYCLES, 1000, cycles at start of each slot with all anodes off; legal range 0 <= BLANK_CYCLES < REFRESH_DIV.
- LZ_BLANK, 0, 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clk  input  1  board clock.
- reset  input  1  asynchronous, active-low reset.
- data  input  16  value to display; integrator drives a 15-bit source zero-extended. Nibble i is shown on digit i; digit 0 is rightmost.
- dp_en  input  4  decimal point enable per digit, bit i applies to digit i.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low.

Behaviour:
- Reset (reset=0, async):
  - cnt=0, digit=0, shadow=16'h0000.
  - Outputs: seg=7'h7F, dp=1, an=4'hF.
- Prescaler:
  - cnt increments every clk.
  - At cnt==REFRESH_DIV-1: cnt->0, and digit advances 0->1->2->3->0 (2-bit wrap).
- Snapshot:
  - When cnt==REFRESH_DIV-1 and digit==3, shadow<=data, same edge.
  - No other loads. The first frame after reset displays shadow=0000.
- Output stage:
  - Registered, one-cycle latency from (cnt, digit, shadow, dp_en, data-independent state).
  - If cnt<BLANK_CYCLES, or digit i is LZ-blanked: an=4'hF, seg=7'h7F, dp=1.
  - Otherwise: an = ~(4'b0001<<digit), seg = decode(shadow[4*digit+3:4*digit]), dp = ~dp_en[digit].
- LZ blanking (LZ_BLANK=1): digit i>0 is blanked iff shadow[15:4*i]==0.
- Decode, active-low, bit order gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Invariants:
  - At most one anode low in any cycle.
  - Frame period = 4*REFRESH_DIV cycles.
- Boundaries:
  - data changes any cycle other than the snapshot edge: no visible effect until next frame.
  - data changes on the snapshot edge: the sampled value is used.
  - BLANK_CYCLES=0: no gap.
  - reset asserted mid-slot: outputs go dark immediately (async). Scan restarts at digit 0, cnt 0, on the first edge after release.
- dp_en is not snapshotted; it is sampled live.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=1 unless noted):
- Reset/first frame:
  - Stimulus: hold reset=0, data=16'h1234, then release.
  - Required: seg=7F, an=F while in reset.
  - Required after release: first frame shows 0 on every digit (seg=40) with an sequence E,D,B,7, each lit 3 cycles after a 1-cycle dark gap.
- Snapshot and decode:
  - Stimulus: after first frame, data=16'h1234 steady.
  - Required: digit0 seg=19 (4), digit1 seg=30 (3), digit2 seg=24 (2), digit3 seg=79 (1).
- Anti-tear:
  - Stimulus: change data 16'hABCD->16'hEF01 while digit=1.
  - Required: remainder of frame still shows B,A (seg=03,08). Next frame shows 1,0,F,E.
- Leading-zero blanking:
  - Stimulus: LZ_BLANK=1, data=16'h0050.
  - Required: digit0 seg=40, digit1 seg=12, digits 2–3 an=F.
  - Stimulus: data=16'h0000.
  - Required: only digit0 lit.
- dp and no-gap:
  - Stimulus: BLANK_CYCLES=0, dp_en=4'b0100.
  - Required: dp=0 only while an=B; an never F after the first slot.
- Async reset mid-slot:
  - Stimulus: assert reset at cnt=2, digit=2.
  - Required: an=F in the same cycle without a clock edge.
  - Required after release: an=F for 1 cycle (gap), then an=E.
